load_store_seq: RTL and testbench

LOAD_STORE_SEQ -- requirements
Module: load_store_seq

---
 rtl/load_store_seq.sv | 195 +++++++++++++++++++
 tb/tb_load_store_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_seq.sv
// load_store_seq: load/store sequencer for a 32-bit word-organised memory.
// Accepts one byte/halfword/word access at a time. A misaligned request that
// crosses a word boundary is split into two word accesses. Load data is
// re-aligned and extended before it is returned on resp_rdata.
module load_store_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_extend,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACC0   | first (or only) word access
  // ACC1   | second word access of a split request
  // WAIT   | last read data returns, result is assembled
  // RESP   | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC0 = 3'd1,
    S_ACC1 = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_store;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_extend;
  logic [31:0] r_word0;
  logic [31:0] r_rdata;

  logic        w_hs;
  logic [1:0]  w_off;
  logic [2:0]  w_len;
  logic        w_split;
  logic [3:0]  w_lane_base;
  logic [7:0]  w_lane_mask;
  logic [31:0] w_base_addr;
  logic [63:0] w_rot64;
  logic [31:0] w_wdata_rot;
  logic [31:0] w_word0;
  logic [31:0] w_word1;
  logic [63:0] w_pair;
  logic [31:0] w_aligned;
  logic [31:0] w_extended;
  logic [31:0] w_load_result;

  assign w_hs  = req_valid && req_ready;
  assign w_off = r_addr[1:0];

  // Size code 11 behaves as a word access.
  always_comb begin
    w_len       = 3'd4;
    w_lane_base = 4'b1111;
    case (r_size)
      2'b01: begin
        w_len       = 3'd2;
        w_lane_base = 4'b0011;
      end
      2'b10: begin
        w_len       = 3'd1;
        w_lane_base = 4'b0001;
      end
      default: begin
        w_len       = 3'd4;
        w_lane_base = 4'b1111;
      end
    endcase
  end

  // Low nibble of the shifted mask covers the first word, high nibble the second.
  assign w_split     = ({1'b0, w_off} + w_len) > 3'd4;
  assign w_lane_mask = {4'b0000, w_lane_base} << w_off;
  assign w_base_addr = {r_addr[31:2], 2'b00};
  assign w_rot64     = {r_wdata, r_wdata} << {w_off, 3'b000};
  assign w_wdata_rot = w_rot64[63:32];

  // In WAIT the last word is still on mem_rdata; it is word1 only when split.
  assign w_word0   = w_split ? r_word0 : mem_rdata;
  assign w_word1   = w_split ? mem_rdata : 32'h0000_0000;
  assign w_pair    = {w_word1, w_word0} >> {w_off, 3'b000};
  assign w_aligned = w_pair[31:0];

  // Keep the low N bytes and sign- or zero-extend from the top kept bit.
  always_comb begin
    w_extended = w_aligned;
    case (w_len)
      3'd1:    w_extended = {{24{r_extend & w_aligned[7]}},  w_aligned[7:0]};
      3'd2:    w_extended = {{16{r_extend & w_aligned[15]}}, w_aligned[15:0]};
      default: w_extended = w_aligned;
    endcase
  end

  assign w_load_result = r_store ? 32'h0000_0000 : w_extended;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_ACC0;
      S_ACC0:  w_next = w_split ? S_ACC1 : S_WAIT;
      S_ACC1:  w_next = S_WAIT;
      S_WAIT:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; memory outputs are zero outside the two access states.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0000_0000;
    mem_be     = 4'b0000;
    mem_wdata  = 32'h0000_0000;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_ACC0: begin
        mem_en    = 1'b1;
        mem_we    = r_store;
        mem_addr  = w_base_addr;
        mem_be    = w_lane_mask[3:0];
        mem_wdata = w_wdata_rot;
      end
      S_ACC1: begin
        mem_en    = 1'b1;
        mem_we    = r_store;
        mem_addr  = w_base_addr + 32'd4;
        mem_be    = w_lane_mask[7:4];
        mem_wdata = w_wdata_rot;
      end
      S_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy       = ~req_ready;
  assign resp_rdata = r_rdata;

  // Request capture on handshake; inputs are ignored at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store  <= 1'b0;
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
      r_size   <= 2'b00;
      r_extend <= 1'b0;
    end else if (w_hs) begin
      r_store  <= req_store;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_size   <= req_size;
      r_extend <= req_extend;
    end
  end

  // First read word of a split load arrives during ACC1; result is registered in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word0 <= 32'h0000_0000;
      r_rdata <= 32'h0000_0000;
    end else begin
      if (r_state == S_ACC1 && !r_store) r_word0 <= mem_rdata;
      if (r_state == S_WAIT)             r_rdata <= w_load_result;
    end
  end

endmodule

// File: tb/tb_load_store_seq.sv
// Directed bench for load_store_seq with a small word memory model and an
// expected-response queue checked whenever resp_valid is seen.
module tb_load_store_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_extend;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int          total;
  int          bad;
  logic [31:0] exp_q[$];

  load_store_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_extend (req_extend),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded words; every other address returns an address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h8899_AABB;
      32'h0000_0104: return 32'h1122_3344;
      default:       return 32'hA5A5_0000 ^ a;
    endcase
  endfunction

  // Read data is returned one cycle after a read strobe; junk otherwise.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_word(mem_addr);
    else                   mem_rdata <= 32'hDEAD_BEEF;
  end

  // Byte-by-byte reference for an extended load.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic ext);
    int          n;
    logic [31:0] r;
    logic [31:0] ba;
    logic [31:0] w;
    n = (sz == 2'b01) ? 2 : ((sz == 2'b10) ? 1 : 4);
    r = 32'h0;
    for (int k = 0; k < n; k++) begin
      ba = a + k;
      w  = mem_word({ba[31:2], 2'b00}) >> {ba[1:0], 3'b000};
      r[8*k +: 8] = w[7:0];
    end
    if (ext && r[8*n-1])
      for (int k = 8*n; k < 32; k++) r[k] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, score any response.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (resp_valid) begin
      total++;
      assert (exp_q.size() > 0)
      else begin
        bad++;
        $error("FAIL resp_unexpected observed=%h expected=none", resp_rdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e);
      end
    end
  endtask

  task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic ext, input logic want_resp,
                       input logic [31:0] exp_r);
    req_store  = st;
    req_addr   = a;
    req_wdata  = wd;
    req_size   = sz;
    req_extend = ext;
    req_valid  = 1'b1;
    chkb("hs_ready", req_ready, 1'b1);
    if (want_resp) exp_q.push_back(exp_r);
    tick();
    // Garbage while busy must not disturb the latched request.
    req_valid  = 1'b0;
    req_store  = ~st;
    req_addr   = 32'hDEAD_BEE1;
    req_wdata  = $urandom;
    req_size   = 2'b10;
    req_extend = ~ext;
  endtask

  task automatic do_req(input logic st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic ext, input logic split,
                        input logic [3:0] be0, input logic [3:0] be1,
                        input logic [31:0] exp_wd, input logic [31:0] exp_r);
    issue(st, a, wd, sz, ext, 1'b1, exp_r);
    chkb("acc0_en",   mem_en, 1'b1);
    chkb("acc0_we",   mem_we, st);
    chk ("acc0_addr", mem_addr, {a[31:2], 2'b00});
    chk ("acc0_be",   {28'd0, mem_be}, {28'd0, be0});
    chk ("acc0_wdata", mem_wdata, exp_wd);
    chkb("acc0_busy", busy, 1'b1);
    if (split) begin
      tick();
      chkb("acc1_en",   mem_en, 1'b1);
      chkb("acc1_we",   mem_we, st);
      chk ("acc1_addr", mem_addr, {a[31:2], 2'b00} + 32'd4);
      chk ("acc1_be",   {28'd0, mem_be}, {28'd0, be1});
      chk ("acc1_wdata", mem_wdata, exp_wd);
      chkb("acc1_busy", busy, 1'b1);
    end
    tick();
    chkb("wait_en",   mem_en, 1'b0);
    chk ("wait_be",   {28'd0, mem_be}, 32'd0);
    chkb("wait_rv",   resp_valid, 1'b0);
    chkb("wait_busy", busy, 1'b1);
    tick();
    chkb("resp_rv",   resp_valid, 1'b1);
    chkb("resp_busy", busy, 1'b1);
    tick();
    chkb("idle_rv",    resp_valid, 1'b0);
    chkb("idle_ready", req_ready, 1'b1);
    chk ("idle_hold",  resp_rdata, exp_r);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_size   = 2'b00;
    req_extend = 1'b0;
    #3;
    chkb("rst_ready", req_ready, 1'b1);
    chkb("rst_busy",  busy, 1'b0);
    chkb("rst_rv",    resp_valid, 1'b0);
    chk ("rst_rdata", resp_rdata, 32'h0);
    chkb("rst_en",    mem_en, 1'b0);
    chk ("rst_addr",  mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // lb 0x103, signed then unsigned
    do_req(1'b0, 32'h103, 32'h0, 2'b10, 1'b1, 1'b0, 4'b1000, 4'b0000, 32'h0, 32'hFFFF_FF88);
    do_req(1'b0, 32'h103, 32'h0, 2'b10, 1'b0, 1'b0, 4'b1000, 4'b0000, 32'h0, 32'h0000_0088);
    // lw 0x102, split
    do_req(1'b0, 32'h102, 32'h0, 2'b00, 1'b0, 1'b1, 4'b1100, 4'b0011, 32'h0, 32'h3344_8899);
    // sh 0xBEEF at 0x103, split store
    do_req(1'b1, 32'h103, 32'h0000_BEEF, 2'b01, 1'b0, 1'b1, 4'b1000, 4'b0001,
           32'hEF00_00BE, 32'h0);
    // sb at 0x101 and aligned sw
    do_req(1'b1, 32'h101, 32'h0000_00A5, 2'b10, 1'b0, 1'b0, 4'b0010, 4'b0000,
           32'h0000_A500, 32'h0);
    do_req(1'b1, 32'h100, 32'h1234_5678, 2'b00, 1'b0, 1'b0, 4'b1111, 4'b0000,
           32'h1234_5678, 32'h0);
    // lh 0x101 signed, lhu 0x103 split, lw 0x104, size 11 as word
    do_req(1'b0, 32'h101, 32'h0, 2'b01, 1'b1, 1'b0, 4'b0110, 4'b0000, 32'h0, 32'hFFFF_99AA);
    do_req(1'b0, 32'h103, 32'h0, 2'b01, 1'b0, 1'b1, 4'b1000, 4'b0001, 32'h0, 32'h0000_4488);
    do_req(1'b0, 32'h104, 32'h0, 2'b00, 1'b1, 1'b0, 4'b1111, 4'b0000, 32'h0, 32'h1122_3344);
    do_req(1'b0, 32'h100, 32'h0, 2'b11, 1'b1, 1'b0, 4'b1111, 4'b0000, 32'h0, 32'h8899_AABB);
    // lw at top of address space wraps the second access to 0
    do_req(1'b0, 32'hFFFF_FFFE, 32'h0, 2'b00, 1'b0, 1'b1, 4'b1100, 4'b0011, 32'h0,
           model_load(32'hFFFF_FFFE, 2'b00, 1'b0));
    chk("wrap_const", resp_rdata, 32'h0000_5A5A);

    // Reset in ACC1 of a split load: no response, outputs clear at once
    issue(1'b0, 32'h102, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    tick();
    chkb("pre_rst_acc1", mem_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chkb("mrst_en",    mem_en, 1'b0);
    chkb("mrst_we",    mem_we, 1'b0);
    chk ("mrst_addr",  mem_addr, 32'h0);
    chk ("mrst_be",    {28'd0, mem_be}, 32'd0);
    chk ("mrst_wdata", mem_wdata, 32'h0);
    chkb("mrst_ready", req_ready, 1'b1);
    chkb("mrst_busy",  busy, 1'b0);
    chkb("mrst_rv",    resp_valid, 1'b0);
    chk ("mrst_rdata", resp_rdata, 32'h0);
    tick();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chkb("post_rst_en", mem_en, 1'b0);
      chkb("post_rst_rv", resp_valid, 1'b0);
    end
    do_req(1'b0, 32'h100, 32'h0, 2'b01, 1'b0, 1'b0, 4'b0011, 4'b0000, 32'h0, 32'h0000_AABB);

    // req_valid held high: accepted only in IDLE, one response per request
    for (int i = 0; i < 20; i++) begin
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_extend = 1'b0;
      if (i % 4 == 0) begin
        req_addr = ((i / 4) % 2 == 1) ? 32'h104 : 32'h100;
        req_size = 2'b00;
        exp_q.push_back(model_load(req_addr, 2'b00, 1'b0));
      end else begin
        req_addr = 32'h103;
        req_size = 2'b10;
      end
      chkb("b2b_ready", req_ready, (i % 4 == 0));
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
